// File: rtl/btn_click_decoder.sv
// Per-button single/double click classifier feeding a small event FIFO on a
// valid/ready stream. Three independent IDLE/WAIT channels, fixed-priority arbiter.
module btn_click_decoder #(
  parameter int unsigned DOUBLE_WINDOW = 25_000_000,
  parameter int unsigned CNT_W         = 25,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] press,
  input  logic       evt_ready,
  input  logic       ovf_clr,
  output logic       evt_valid,
  output logic [1:0] evt_btn,
  output logic       evt_double,
  output logic       overflow
);

  localparam int unsigned      NCH     = 3;
  localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] WIN     = CNT_W'(DOUBLE_WINDOW);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state_q [NCH];
  state_t           state_d [NCH];
  logic [CNT_W-1:0] cnt_q   [NCH];
  logic [CNT_W-1:0] cnt_d   [NCH];
  logic [NCH-1:0]   gen;
  logic [NCH-1:0]   gen_dbl;

  logic [NCH-1:0]   pend_v_q;
  logic [NCH-1:0]   pend_dbl_q;
  logic [NCH-1:0]   moved;
  logic [1:0]       sel;
  logic             move;
  logic             pop;
  logic             drop;

  logic [1:0]       mem_btn [FIFO_DEPTH];
  logic             mem_dbl [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;

  // Channel FSMs: a press while waiting always wins over the timeout.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      gen[i]     = 1'b0;
      gen_dbl[i] = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (press[i]) begin
            state_d[i] = WAIT;
            cnt_d[i]   = CNT_W'(1);
          end
        end
        WAIT: begin
          if (press[i]) begin
            gen[i]     = 1'b1;
            gen_dbl[i] = 1'b1;
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == WIN) begin
            gen[i]     = 1'b1;
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // A pop frees a slot on the same edge, so a full FIFO can still accept a move.
  always_comb begin
    pop   = evt_valid && evt_ready;
    move  = 1'b0;
    sel   = '0;
    moved = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (pend_v_q[i] && !move && ((count_q < DEPTH_C) || pop)) begin
        move     = 1'b1;
        sel      = 2'(i);
        moved[i] = 1'b1;
      end
    end
    drop = |(gen & pend_v_q & ~moved);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_v_q   <= '0;
      pend_dbl_q <= '0;
      overflow   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (gen[i] && (!pend_v_q[i] || moved[i])) begin
          pend_v_q[i]   <= 1'b1;
          pend_dbl_q[i] <= gen_dbl[i];
        end else if (moved[i]) begin
          pend_v_q[i]   <= 1'b0;
        end
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (move) begin
      mem_btn[wr_ptr] <= sel;
      mem_dbl[wr_ptr] <= pend_dbl_q[sel];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (move) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({move, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign evt_valid  = (count_q != '0);
  assign evt_btn    = evt_valid ? mem_btn[rd_ptr] : '0;
  assign evt_double = evt_valid ? mem_dbl[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_btn_click_decoder.sv
// Bench for btn_click_decoder: timestamp/queue reference model checked every
// cycle, plus literal checks pinning the latencies of the directed scenarios.
module tb_btn_click_decoder;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] press = '0;
  logic       evt_ready = 1'b1;
  logic       ovf_clr = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_btn;
  logic       evt_double;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  btn_click_decoder #(
    .DOUBLE_WINDOW(DW),
    .CNT_W(4),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .press(press),
    .evt_ready(evt_ready),
    .ovf_clr(ovf_clr),
    .evt_valid(evt_valid),
    .evt_btn(evt_btn),
    .evt_double(evt_double),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel remembers when its first press happened;
  // events wait in a per-button slot, then join a queue bounded by DEPTH.
  int first_t [3] = '{-1, -1, -1};
  int pend    [3] = '{-1, -1, -1};
  int q_btn [$];
  int q_dbl [$];
  bit m_ovf = 0;
  int cyc = 0;
  bit m_gen [3];
  int m_gdbl [3];
  bit m_pop;
  bit m_drop;
  int m_mv;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      first_t = '{-1, -1, -1};
      pend    = '{-1, -1, -1};
      q_btn.delete();
      q_dbl.delete();
      m_ovf = 0;
      cyc   = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_gen[i]  = 0;
        m_gdbl[i] = 0;
        if (first_t[i] >= 0) begin
          if (press[i]) begin
            m_gen[i] = 1; m_gdbl[i] = 1; first_t[i] = -1;
          end else if (cyc - first_t[i] == DW) begin
            m_gen[i] = 1; m_gdbl[i] = 0; first_t[i] = -1;
          end
        end else if (press[i]) begin
          first_t[i] = cyc;
        end
      end
      m_pop = (q_btn.size() > 0) && evt_ready;
      m_mv  = -1;
      if (q_btn.size() < DEPTH || m_pop)
        for (int i = 0; i < 3; i++)
          if (pend[i] >= 0 && m_mv < 0) m_mv = i;
      if (m_pop) begin
        void'(q_btn.pop_front());
        void'(q_dbl.pop_front());
      end
      if (m_mv >= 0) begin
        q_btn.push_back(m_mv);
        q_dbl.push_back(pend[m_mv]);
        pend[m_mv] = -1;
      end
      m_drop = 0;
      for (int i = 0; i < 3; i++)
        if (m_gen[i]) begin
          if (pend[i] >= 0) m_drop = 1;
          else pend[i] = m_gdbl[i];
        end
      if (m_drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      cyc++;
    end
  end

  always @(negedge clk) begin
    check("valid", int'(evt_valid), int'(q_btn.size() > 0));
    if (evt_valid && q_btn.size() > 0) begin
      check("btn", int'(evt_btn), q_btn[0]);
      check("double", int'(evt_double), q_dbl[0]);
    end
    check("overflow", int'(overflow), int'(m_ovf));
  end

  task automatic pulse(input logic [2:0] m);
    press = m;
    @(posedge clk); #1;
    press = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", int'(evt_valid), 0);
    check("rst_btn", int'(evt_btn), 0);
    check("rst_double", int'(evt_double), 0);
    check("rst_ovf", int'(overflow), 0);
    reset = 1'b0;
    idle(1);

    // single click on L
    pulse(3'b001); idle(8);
    check("t1_pending", int'(evt_valid), 0);
    idle(1);
    check("t1_valid", int'(evt_valid), 1);
    check("t1_btn", int'(evt_btn), 0);
    check("t1_dbl", int'(evt_double), 0);
    idle(1);
    check("t1_popped", int'(evt_valid), 0);

    // double at k=8, then k=9 splits into SINGLE + new sequence
    pulse(3'b010); idle(7); pulse(3'b010); idle(1);
    check("t2_dvalid", int'(evt_valid), 1);
    check("t2_dbtn", int'(evt_btn), 1);
    check("t2_ddbl", int'(evt_double), 1);
    idle(10); pulse(3'b010); idle(8); pulse(3'b010);
    check("t2_svalid", int'(evt_valid), 1);
    check("t2_sdbl", int'(evt_double), 0);
    idle(20);

    // simultaneous presses
    pulse(3'b111); idle(9);
    check("t3_head0", int'(evt_btn), 0);
    idle(1);
    check("t3_head1", int'(evt_btn), 1);
    idle(1);
    check("t3_head2", int'(evt_btn), 2);
    check("t3_ovf", int'(overflow), 0);
    idle(5);

    // fill FIFO with ready low, overflow, drain, clear
    evt_ready = 1'b0;
    repeat (5) begin pulse(3'b001); idle(8); end
    idle(1);
    check("t4_full_valid", int'(evt_valid), 1);
    check("t4_full_ovf", int'(overflow), 0);
    pulse(3'b001); idle(8);
    check("t4_ovf", int'(overflow), 1);
    evt_ready = 1'b1;
    idle(1);
    check("t6_still_valid", int'(evt_valid), 1);
    idle(4);
    check("t4_drained", int'(evt_valid), 0);
    ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
    check("t4_ovf_clr", int'(overflow), 0);

    // reset mid-WAIT with events queued
    evt_ready = 1'b0;
    pulse(3'b100); idle(8); pulse(3'b100); idle(8); idle(2);
    check("t5_queued", int'(evt_valid), 1);
    pulse(3'b010); idle(3);
    #2 reset = 1'b1;
    #1 check("t5_async", int'(evt_valid), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    evt_ready = 1'b1;
    pulse(3'b010); idle(8);
    check("t5_fresh_pending", int'(evt_valid), 0);
    idle(1);
    check("t5_fresh_valid", int'(evt_valid), 1);
    check("t5_fresh_btn", int'(evt_btn), 1);
    idle(3);

    // mixed traffic against the model, ready mostly low early on
    for (int c = 0; c < 600; c++) begin
      press     = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      evt_ready = (c < 300) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
      ovf_clr   = ($urandom_range(0, 20) == 0);
      @(posedge clk); #1;
    end
    press = '0; ovf_clr = 1'b0; evt_ready = 1'b1;
    idle(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
